// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration interface: source-side requests/data and arbiter-side grant/bus.
interface bus_arbiter_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 6
);
   localparam int OW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0]       req;
   logic [CHANNELS-1:0]       last;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic [CHANNELS-1:0]       grant;
   logic [OW-1:0]             owner;
   logic [WIDTH-1:0]          bus;
   logic                      bus_valid;
   logic                      preempt;

   modport master (
      input  req, last, data_in,
      output grant, owner, bus, bus_valid, preempt
   );

   modport slave (
      output req, last, data_in,
      input  grant, owner, bus, bus_valid, preempt
   );
endinterface

// File: rtl/bus_arbiter.sv
// Clocked shared-bus arbiter: fixed-priority or round-robin, multi-cycle ownership
// with end-of-transfer marker and hold-limit preemption.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no owner, bus driven to zero
//   ST_BUSY | one owner granted, its data_in drives the bus
module bus_arbiter #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 6,
   parameter int MODE     = 0,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_arbiter_if.master arb
);
   localparam int OW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int HW = $clog2(MAX_HOLD + 2);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t              state_q, state_d;
   logic [CHANNELS-1:0] grant_q, grant_d;
   logic [OW-1:0]       owner_q, owner_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [OW-1:0]       ptr_q, ptr_d;
   logic                preempt_q, preempt_d;

   logic [CHANNELS-1:0] cand;
   logic                own_req, own_last, others, hold_hit, release_c;
   logic                found;
   logic [OW-1:0]       win;

   // Returns {found, index}. Round-robin scans upward starting just after ptr.
   function automatic logic [OW:0] pick(input logic [CHANNELS-1:0] c, input logic [OW-1:0] ptr);
      logic          f;
      logic [OW-1:0] idx;
      int            j;
      f   = 1'b0;
      idx = '0;
      if (MODE == 0) begin
         for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (c[i]) begin
               f   = 1'b1;
               idx = OW'(i);
            end
         end
      end else begin
         for (int k = CHANNELS; k >= 1; k--) begin
            j = (int'(ptr) + k) % CHANNELS;
            if (c[j]) begin
               f   = 1'b1;
               idx = OW'(j);
            end
         end
      end
      return {f, idx};
   endfunction

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      ptr_d     = ptr_q;
      preempt_d = 1'b0;

      own_req   = |(arb.req & grant_q);
      own_last  = |(arb.last & grant_q);
      others    = |(arb.req & ~grant_q);
      hold_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && others;
      release_c = !own_req || own_last || hold_hit;

      cand = (state_q == ST_IDLE) ? arb.req : (arb.req & ~grant_q);
      {found, win} = pick(cand, ptr_q);

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_BUSY;
               grant_d = CHANNELS'(1) << win;
               owner_d = win;
               hold_d  = HW'(1);
               ptr_d   = win;
            end
         end
         ST_BUSY: begin
            if (release_c) begin
               if (found) begin
                  grant_d   = CHANNELS'(1) << win;
                  owner_d   = win;
                  hold_d    = HW'(1);
                  ptr_d     = win;
                  // last or a dropped request take precedence over a preemption report
                  preempt_d = hold_hit && own_req && !own_last;
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  owner_d = '0;
                  hold_d  = '0;
               end
            end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            owner_d = '0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         hold_q    <= '0;
         ptr_q     <= OW'(CHANNELS - 1);
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         ptr_q     <= ptr_d;
         preempt_q <= preempt_d;
      end
   end

   always_comb begin
      arb.bus = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant_q[i]) arb.bus = arb.data_in[i*WIDTH +: WIDTH];
      end
   end

   assign arb.grant     = grant_q;
   assign arb.owner     = owner_q;
   assign arb.bus_valid = (state_q == ST_BUSY);
   assign arb.preempt   = preempt_q;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised, clocked successor to the CPU's combinational priority bus mux. It arbitrates CHANNELS word-wide sources onto one shared bus. It supports fixed-priority or round-robin selection, multi-cycle ownership with an end-of-transfer marker, and hold-limit preemption. It sits between the register/ALU/RAM/PC/IR output enables and the shared bus, and replaces the per-source if/else chain.

## Interface
Parameters:
- WIDTH, 16, bus and source data width in bits
- CHANNELS, 6, number of requesting sources (2..16)
- MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- MAX_HOLD, 4, maximum consecutive granted cycles before preemption when another channel is waiting; 0 disables preemption

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  CHANNELS  per-channel bus request (level)
- last  input  CHANNELS  per-channel end-of-transfer marker, honoured only for the current owner
- data_in  input  CHANNELS*WIDTH  source data, channel i at bits [i*WIDTH +: WIDTH]
- grant  output  CHANNELS  one-hot ownership (all-zero when idle)
- owner  output  clog2(CHANNELS)  index of current owner, 0 when idle
- bus  output  WIDTH  data_in of owner while granted, all-zero when idle (combinational from registered owner)
- bus_valid  output  1  high while any grant is active
- preempt  output  1  one-cycle pulse on the edge a hold-limit preemption takes effect

## Operation
- Two states: IDLE (no grant), BUSY (one owner).
- IDLE: if any req bit is high at an edge, enter BUSY with the arbitration winner. Otherwise stay.
- BUSY, release conditions checked each edge:
  - owner's req low;
  - owner's last high;
  - MAX_HOLD != 0, hold count == MAX_HOLD, and any other req high (preemption, sets preempt).
- On release, arbitrate among requesting channels, excluding the releasing owner:
  - a winner exists: grant moves directly to it (back-to-back, no idle cycle);
  - no winner: return to IDLE. An owner still requesting after its own release is re-granted from IDLE one cycle later.
- No release: owner kept, hold count increments (saturating at MAX_HOLD).
- Hold count resets to 1 on every new grant.
- Fixed-priority winner: lowest requesting index.
- Round-robin winner: first requesting index after the last-granted index, wrapping modulo CHANNELS. The pointer updates to the winner on every grant.
- bus = 0 and bus_valid = 0 in IDLE; grant is always one-hot or zero.
- data_in changes on the owner are passed through the same cycle; non-owner data is ignored.

## Timing
- Reset (asynchronous assert, synchronous-edge release) sets:
  - state IDLE;
  - grant 0, owner 0, bus 0, bus_valid 0, preempt 0;
  - hold count 0;
  - RR pointer CHANNELS-1, so channel 0 has first priority.
- Reset mid-transfer drops grant immediately, without waiting for a clock.
- Grant latency: req high before edge N gives grant valid after edge N (1 cycle).
- A transfer with last asserted in cycle k occupies the bus for cycle k inclusive. The next owner drives from cycle k+1.
- Owner req falling before edge N removes grant after edge N.
- Owner req and last asserted together are treated as a single release.
- A hold-limit preemption and last in the same cycle are reported as a release with preempt = 0.
- preempt is high only in the first cycle of the new owner's grant.

## Test plan
- Fixed mode, CHANNELS=4, WIDTH=16: req=4'b1010 from idle, data_in[1]=16'h1234 → after one edge grant=4'b0010, owner=1, bus=16'h1234, bus_valid=1.
- Round-robin, all four req held high, each owner pulses last on its first granted cycle → grants cycle 0,1,2,3,0 on consecutive edges with no idle gap.
- MAX_HOLD=4: channel 2 holds req without last, channel 0 raises req at cycle 2 of the grant → grant stays on 2 for exactly 4 cycles, then moves to 0 with preempt pulsing high for one cycle.
- MAX_HOLD=4 with only channel 3 requesting for 10 cycles → grant stays 4'b1000 throughout, preempt never asserts.
- Owner 1 drops req with no other requesters → next edge grant=0, bus=16'h0000, bus_valid=0.
- rst_n pulsed low mid-transfer (owner 2) → grant, bus and bus_valid go to 0 without waiting for a clock. After release with req=4'b0110 in RR mode, channel 1 is granted first.
